scratchpad_bank_ctrl: RTL

//  Parametrised scratchpad bank: NUM_MATS matrices x ROWS rows x DATA_W bits, flop array, single port.

---
 rtl/scratchpad_bank_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/scratchpad_bank_ctrl.sv
// rtl/scratchpad_bank_ctrl.sv - single-port scratchpad bank with buffered fill writes and routed reads
//
// Purpose
//   NUM_MATS x ROWS x DATA_W flop array behind a write FIFO (DRAM fills) and a
//   read-request FIFO. One array access is granted per cycle. Read data is
//   returned through either a DRAM or a GEMM response FIFO.
//
// Ports
//   CLK, RST                          clock, synchronous active-high reset
//   wFIFO_WEN / wFIFO_wdata / _full   write push {mat,row,data}
//   rFIFO_WEN / rFIFO_wdata / _full   read push {dest,last,tag,mat,row}
//   dramFIFO_REN / _rdata / _empty    DRAM response pop, head {tag,mat,row,data}
//   gemmFIFO_REN / _rdata / _empty    GEMM response pop, head {last,mat,row,data}
//   gemm_complete                     pulse when a GEMM word with last=1 is enqueued
//   ovf_err                           sticky push-on-full / pop-on-empty flag

module scratchpad_bank_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic [W-1:0]  wdata,
    input  logic          ren,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          err
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Flags come from the registered count, so a push while full is dropped
    // even when the same cycle also pops.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wen && !full;
    assign pop   = ren && !empty;
    assign err   = (wen && full) || (ren && empty);

    // Head is forced to zero while empty so stale storage never shows.
    assign rdata = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wdata;
    end
endmodule

module scratchpad_bank_ctrl #(
    parameter int NUM_MATS   = 4,
    parameter int ROWS       = 4,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 3,
    localparam int MW = (NUM_MATS > 1) ? $clog2(NUM_MATS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          wFIFO_WEN,
    input  logic [MW+RW+DATA_W-1:0]       wFIFO_wdata,
    output logic                          wFIFO_full,
    input  logic                          rFIFO_WEN,
    input  logic [2+TAG_W+MW+RW-1:0]      rFIFO_wdata,
    output logic                          rFIFO_full,
    input  logic                          dramFIFO_REN,
    output logic [TAG_W+MW+RW+DATA_W-1:0] dramFIFO_rdata,
    output logic                          dramFIFO_empty,
    input  logic                          gemmFIFO_REN,
    output logic [1+MW+RW+DATA_W-1:0]     gemmFIFO_rdata,
    output logic                          gemmFIFO_empty,
    output logic                          gemm_complete,
    output logic                          ovf_err
);
    localparam int WF_W = MW + RW + DATA_W;
    localparam int RF_W = 2 + TAG_W + MW + RW;
    localparam int DF_W = TAG_W + MW + RW + DATA_W;
    localparam int GF_W = 1 + MW + RW + DATA_W;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    logic [WF_W-1:0]   wHead;
    logic [RF_W-1:0]   rHead;
    logic [CW-1:0]     wCnt, rCnt, dramCnt, gemmCnt;
    logic              wErr, rErr, dramErr, gemmErr;
    logic              wGrant, rGrant;
    logic              wOk, rOk;
    logic [SW-1:0]     starveCnt;

    logic [DATA_W-1:0] arr [NUM_MATS][ROWS];

    // Read pipeline stage: one registered array read in flight.
    logic              pValid;
    logic              pDest;
    logic              pLast;
    logic [TAG_W-1:0]  pTag;
    logic [MW-1:0]     pMat;
    logic [RW-1:0]     pRow;
    logic [DATA_W-1:0] pData;

    scratchpad_bank_fifo #(.W(WF_W), .DEPTH(FIFO_DEPTH)) wFifo (
        .clk(CLK), .rst(RST), .wen(wFIFO_WEN), .wdata(wFIFO_wdata),
        .ren(wGrant), .rdata(wHead), .count(wCnt), .err(wErr)
    );

    scratchpad_bank_fifo #(.W(RF_W), .DEPTH(FIFO_DEPTH)) rFifo (
        .clk(CLK), .rst(RST), .wen(rFIFO_WEN), .wdata(rFIFO_wdata),
        .ren(rGrant), .rdata(rHead), .count(rCnt), .err(rErr)
    );

    scratchpad_bank_fifo #(.W(DF_W), .DEPTH(FIFO_DEPTH)) dramFifo (
        .clk(CLK), .rst(RST), .wen(pValid && !pDest), .wdata({pTag, pMat, pRow, pData}),
        .ren(dramFIFO_REN), .rdata(dramFIFO_rdata), .count(dramCnt), .err(dramErr)
    );

    scratchpad_bank_fifo #(.W(GF_W), .DEPTH(FIFO_DEPTH)) gemmFifo (
        .clk(CLK), .rst(RST), .wen(pValid && pDest), .wdata({pLast, pMat, pRow, pData}),
        .ren(gemmFIFO_REN), .rdata(gemmFIFO_rdata), .count(gemmCnt), .err(gemmErr)
    );

    assign wFIFO_full     = (wCnt == CW'(FIFO_DEPTH));
    assign rFIFO_full     = (rCnt == CW'(FIFO_DEPTH));
    assign dramFIFO_empty = (dramCnt == '0);
    assign gemmFIFO_empty = (gemmCnt == '0);

    // Head field decode
    logic [MW-1:0]     wMat;
    logic [RW-1:0]     wRow;
    logic [DATA_W-1:0] wData;
    logic              rDest;
    logic              rLast;
    logic [TAG_W-1:0]  rTag;
    logic [MW-1:0]     rMat;
    logic [RW-1:0]     rRow;

    assign wMat  = wHead[WF_W-1 -: MW];
    assign wRow  = wHead[DATA_W +: RW];
    assign wData = wHead[DATA_W-1:0];
    assign rDest = rHead[RF_W-1];
    assign rLast = rHead[RF_W-2];
    assign rTag  = rHead[MW+RW +: TAG_W];
    assign rMat  = rHead[RW +: MW];
    assign rRow  = rHead[RW-1:0];

    logic wInRange;
    logic rInRange;
    assign wInRange = (int'(wMat) < NUM_MATS) && (int'(wRow) < ROWS);
    assign rInRange = (int'(rMat) < NUM_MATS) && (int'(rRow) < ROWS);

    // A read is only issued when its response is guaranteed a slot: the
    // destination occupancy plus the word already in the pipeline toward it
    // must leave room. Pops in the same cycle are not credited.
    logic [CW-1:0] destCnt;
    logic          inFlight;
    assign destCnt  = rDest ? gemmCnt : dramCnt;
    assign inFlight = pValid && (pDest == rDest);
    assign wOk      = (wCnt != '0);
    assign rOk      = (rCnt != '0) && ((destCnt + CW'(inFlight)) < CW'(FIFO_DEPTH));

    always_comb begin
        wGrant = 1'b0;
        rGrant = 1'b0;
        if (wOk && rOk) begin
            if (starveCnt == SW'(STARVE_LIM)) rGrant = 1'b1;
            else                              wGrant = 1'b1;
        end else if (wOk) begin
            wGrant = 1'b1;
        end else if (rOk) begin
            rGrant = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starveCnt <= '0;
        end else if (!rOk || rGrant) begin
            starveCnt <= '0;
        end else if (starveCnt != SW'(STARVE_LIM)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    // Writes land at the grant edge, so a read granted on the next cycle
    // already sees the new word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int m = 0; m < NUM_MATS; m++) begin
                for (int r = 0; r < ROWS; r++) begin
                    arr[m][r] <= '0;
                end
            end
        end else if (wGrant && wInRange) begin
            arr[wMat][wRow] <= wData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pValid <= 1'b0;
            pDest  <= 1'b0;
            pLast  <= 1'b0;
            pTag   <= '0;
            pMat   <= '0;
            pRow   <= '0;
            pData  <= '0;
        end else begin
            pValid <= rGrant;
            if (rGrant) begin
                pDest <= rDest;
                pLast <= rLast;
                pTag  <= rTag;
                pMat  <= rMat;
                pRow  <= rRow;
                pData <= rInRange ? arr[rMat][rRow] : '0;
            end
        end
    end

    assign gemm_complete = pValid && pDest && pLast;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_err <= 1'b0;
        end else if (wErr || rErr || dramErr || gemmErr) begin
            ovf_err <= 1'b1;
        end
    end
endmodule
